// File: rtl/adr_nib_pkg.sv
// Shared types, lane map and unswizzle helper for the address-lane nibble receiver.
// Defining ADR_RX_PARITY_EN adds the CHECK state used by the parity option.
package adr_nib_pkg;

  localparam int NIB_W      = 4;
  localparam int LANE_IDX_W = $clog2(NIB_W);

  typedef logic [NIB_W-1:0][LANE_IDX_W-1:0] lane_map_t;

  // Indexed by logical bit, gives the physical pin that carries it.
  localparam lane_map_t LANE_MAP = {2'd0, 2'd2, 2'd1, 2'd3};

`ifdef ADR_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
`endif

  function automatic logic [NIB_W-1:0] unswizzle(input logic [NIB_W-1:0] nib,
                                                 input lane_map_t        map);
    logic [NIB_W-1:0] d;
    for (int i = 0; i < NIB_W; i++) begin
      d[i] = nib[map[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/adr_nib_unswizzle.sv
// Combinational lane permutation; the driver side instantiates it with the inverse map.
module adr_nib_unswizzle
  import adr_nib_pkg::*;
#(
  parameter lane_map_t MAP = LANE_MAP
) (
  input  logic [NIB_W-1:0] i_nib,
  output logic [NIB_W-1:0] o_d
);

  assign o_d = unswizzle(i_nib, MAP);

endmodule

// File: rtl/adr_nibble_rx.sv
// Reassembles permuted address nibbles into WORD_W-bit words on a valid/ready output.
// Defining ADR_RX_PARITY_EN adds par_i and an even-parity check before delivery.
module adr_nibble_rx
  import adr_nib_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIB_W-1:0]  nib_i,
  input  logic              nib_vld_i,
  input  logic              nib_sof_i,
`ifdef ADR_RX_PARITY_EN
  input  logic              par_i,
`endif
  output logic              nib_rdy_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o,
  input  logic              word_rdy_i,
  output logic              err_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int              NIB_CNT  = WORD_W / NIB_W;
  localparam int              IDX_W    = $clog2(NIB_CNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_CNT - 1);
  localparam logic [WORD_W-1:0] NIB_MASK = WORD_W'({NIB_W{1'b1}});

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic [WORD_W-1:0]   r_word;
  logic                r_err;
  logic [7:0]          r_frame_cnt;
  logic [NIB_W-1:0]    w_d;
  logic                w_accept;
  logic                w_store;
  logic                w_complete;
  logic                w_err_next;
  logic [IDX_W-1:0]    w_pos;
  logic [WORD_W-1:0]   w_base;
  logic [WORD_W-1:0]   w_word_new;
`ifdef ADR_RX_PARITY_EN
  logic                r_par_bad;
`endif

  function automatic logic [WORD_W-1:0] place(input logic [WORD_W-1:0] word,
                                              input logic [NIB_W-1:0]  d,
                                              input logic [IDX_W-1:0]  pos);
    int lo;
    if (MSB_FIRST != 0) lo = WORD_W - NIB_W * (int'(pos) + 1);
    else                lo = NIB_W * int'(pos);
    return (word & ~(NIB_MASK << lo)) | (WORD_W'(d) << lo);
  endfunction

  adr_nib_unswizzle u_unswizzle (
    .i_nib (nib_i),
    .o_d   (w_d)
  );

  assign nib_rdy_o   = !rst && (r_state == IDLE || r_state == COLLECT);
  assign word_vld_o  = (r_state == HOLD);
  assign word_o      = r_word;
  assign err_o       = r_err;
  assign frame_cnt_o = r_frame_cnt;

  assign w_accept   = nib_vld_i && nib_rdy_o;
  // A start-of-frame nibble always restarts at position 0 on a cleared word.
  assign w_pos      = (nib_sof_i || r_state == IDLE) ? '0 : r_idx;
  assign w_base     = (nib_sof_i || r_state == IDLE) ? '0 : r_word;
  assign w_word_new = place(w_base, w_d, w_pos);
  assign w_store    = w_accept && (nib_sof_i || r_state == COLLECT);
  assign w_complete = w_store && (w_pos == LAST_IDX);

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (nib_sof_i) w_state_next = COLLECT;
          else           w_err_next   = 1'b1;
        end
      end
      COLLECT: begin
        if (w_accept && nib_sof_i) w_err_next = 1'b1;
`ifdef ADR_RX_PARITY_EN
        if (w_complete) w_state_next = CHECK;
`else
        if (w_complete) w_state_next = HOLD;
`endif
      end
`ifdef ADR_RX_PARITY_EN
      CHECK: begin
        if (r_par_bad) begin
          w_err_next   = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = HOLD;
        end
      end
`endif
      HOLD: begin
        if (word_rdy_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word      <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_err <= w_err_next;
      if (w_store) begin
        r_word <= w_word_new;
        r_idx  <= w_complete ? '0 : w_pos + 1'b1;
      end
      if (word_vld_o && word_rdy_i) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

`ifdef ADR_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)             r_par_bad <= 1'b0;
    else if (w_complete) r_par_bad <= ((^w_word_new) != par_i);
  end
`endif

endmodule

// File: tb/tb_adr_nibble_rx.sv
// Directed bench for adr_nibble_rx: one MSB-first and one LSB-first instance share stimulus.
// The parity scenario is compiled in only when ADR_RX_PARITY_EN is defined.
module tb_adr_nibble_rx;

`ifdef ADR_RX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  nib_i;
  logic        nib_vld_i;
  logic        nib_sof_i;
  logic        word_rdy_i;
`ifdef ADR_RX_PARITY_EN
  logic        par_i;
`endif
  logic        nib_rdy_o,   l_nib_rdy_o;
  logic [15:0] word_o,      l_word_o;
  logic        word_vld_o,  l_word_vld_o;
  logic        err_o,       l_err_o;
  logic [7:0]  frame_cnt_o, l_frame_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  adr_nibble_rx #(.WORD_W(16), .MSB_FIRST(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .nib_i       (nib_i),
    .nib_vld_i   (nib_vld_i),
    .nib_sof_i   (nib_sof_i),
`ifdef ADR_RX_PARITY_EN
    .par_i       (par_i),
`endif
    .nib_rdy_o   (nib_rdy_o),
    .word_o      (word_o),
    .word_vld_o  (word_vld_o),
    .word_rdy_i  (word_rdy_i),
    .err_o       (err_o),
    .frame_cnt_o (frame_cnt_o)
  );

  adr_nibble_rx #(.WORD_W(16), .MSB_FIRST(0)) dut_lsb (
    .clk         (clk),
    .rst         (rst),
    .nib_i       (nib_i),
    .nib_vld_i   (nib_vld_i),
    .nib_sof_i   (nib_sof_i),
`ifdef ADR_RX_PARITY_EN
    .par_i       (par_i),
`endif
    .nib_rdy_o   (l_nib_rdy_o),
    .word_o      (l_word_o),
    .word_vld_o  (l_word_vld_o),
    .word_rdy_i  (word_rdy_i),
    .err_o       (l_err_o),
    .frame_cnt_o (l_frame_cnt_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n, input logic sof);
    nib_i     = n;
    nib_sof_i = sof;
    nib_vld_i = 1'b1;
    step();
    nib_vld_i = 1'b0;
    nib_sof_i = 1'b0;
  endtask

  // Sends one full frame and waits out any parity-check cycle, leaving the DUT in HOLD.
  task automatic send_frame(input logic [3:0] n0, input logic [3:0] n1,
                            input logic [3:0] n2, input logic [3:0] n3);
    send_nib(n0, 1'b1);
    send_nib(n1, 1'b0);
    send_nib(n2, 1'b0);
    send_nib(n3, 1'b0);
    repeat (EXTRA) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nib_i = 4'h1; nib_sof_i = 1'b1; nib_vld_i = 1'b1;
    step();
    step();
    n_total++; if (nib_rdy_o !== 1'b0) $display("FAIL reset_nib_rdy: got %b want 0", nib_rdy_o); else n_pass++;
    n_total++; if (word_o !== 16'h0000) $display("FAIL reset_word: got %h want 0000", word_o); else n_pass++;
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL reset_word_vld: got %b want 0", word_vld_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    n_total++; if (frame_cnt_o !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt_o); else n_pass++;
    nib_vld_i = 1'b0; nib_sof_i = 1'b0;
    rst = 1'b0;
    #1;
    n_total++; if (nib_rdy_o !== 1'b1) $display("FAIL reset_release_rdy: got %b want 1", nib_rdy_o); else n_pass++;
  endtask

  task automatic test_basic();
    word_rdy_i = 1'b1;
`ifdef ADR_RX_PARITY_EN
    par_i = 1'b1;
`endif
    send_nib(4'h1, 1'b1);
    send_nib(4'h2, 1'b0);
    send_nib(4'h3, 1'b0);
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL basic_vld_early: got %b want 0", word_vld_o); else n_pass++;
    send_nib(4'h4, 1'b0);
    repeat (EXTRA) step();
    n_total++; if (word_vld_o !== 1'b1) $display("FAIL basic_vld: got %b want 1", word_vld_o); else n_pass++;
    n_total++; if (word_o !== 16'h82A4) $display("FAIL basic_word_msb: got %h want 82a4", word_o); else n_pass++;
    n_total++; if (l_word_vld_o !== 1'b1) $display("FAIL basic_vld_lsb: got %b want 1", l_word_vld_o); else n_pass++;
    n_total++; if (l_word_o !== 16'h4A28) $display("FAIL basic_word_lsb: got %h want 4a28", l_word_o); else n_pass++;
    n_total++; if (nib_rdy_o !== 1'b0) $display("FAIL basic_rdy_hold: got %b want 0", nib_rdy_o); else n_pass++;
    step();
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL basic_vld_drop: got %b want 0", word_vld_o); else n_pass++;
    n_total++; if (frame_cnt_o !== 8'd1) $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt_o); else n_pass++;
    n_total++; if (l_frame_cnt_o !== 8'd1) $display("FAIL basic_frame_cnt_lsb: got %0d want 1", l_frame_cnt_o); else n_pass++;
    n_total++; if (l_nib_rdy_o !== 1'b1) $display("FAIL basic_rdy_idle_lsb: got %b want 1", l_nib_rdy_o); else n_pass++;
    n_total++; if (err_o !== 1'b0 || l_err_o !== 1'b0) $display("FAIL basic_no_err: got %b/%b want 0/0", err_o, l_err_o); else n_pass++;
`ifdef ADR_RX_PARITY_EN
    par_i = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    word_rdy_i = 1'b0;
    send_frame(4'h8, 4'h4, 4'h2, 4'h1);
    nib_i = 4'h5; nib_sof_i = 1'b1; nib_vld_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_total++; if (word_vld_o !== 1'b1) $display("FAIL bp_vld_c%0d: got %b want 1", c, word_vld_o); else n_pass++;
      n_total++; if (word_o !== 16'h1428) $display("FAIL bp_word_c%0d: got %h want 1428", c, word_o); else n_pass++;
      n_total++; if (nib_rdy_o !== 1'b0) $display("FAIL bp_rdy_c%0d: got %b want 0", c, nib_rdy_o); else n_pass++;
      step();
    end
    n_total++; if (l_word_o !== 16'h8241) $display("FAIL bp_word_lsb: got %h want 8241", l_word_o); else n_pass++;
    n_total++; if (frame_cnt_o !== 8'd1) $display("FAIL bp_cnt_held: got %0d want 1", frame_cnt_o); else n_pass++;
    nib_vld_i = 1'b0; nib_sof_i = 1'b0;
    word_rdy_i = 1'b1;
    step();
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL bp_release_vld: got %b want 0", word_vld_o); else n_pass++;
    n_total++; if (frame_cnt_o !== 8'd2) $display("FAIL bp_release_cnt: got %0d want 2", frame_cnt_o); else n_pass++;
    n_total++; if (nib_rdy_o !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", nib_rdy_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL bp_no_err: got %b want 0", err_o); else n_pass++;
  endtask

  task automatic test_framing();
    word_rdy_i = 1'b1;
    send_nib(4'h5, 1'b0);
    n_total++; if (err_o !== 1'b1) $display("FAIL frm_idle_err: got %b want 1", err_o); else n_pass++;
    step();
    n_total++; if (err_o !== 1'b0) $display("FAIL frm_idle_err_pulse: got %b want 0", err_o); else n_pass++;
    n_total++; if (word_vld_o !== 1'b0 || frame_cnt_o !== 8'd2) $display("FAIL frm_idle_drop: got vld %b cnt %0d want 0 2", word_vld_o, frame_cnt_o); else n_pass++;
    send_nib(4'h1, 1'b1);
    send_nib(4'h2, 1'b0);
    n_total++; if (err_o !== 1'b0) $display("FAIL frm_mid_no_err: got %b want 0", err_o); else n_pass++;
    send_nib(4'h0, 1'b1);
    n_total++; if (err_o !== 1'b1) $display("FAIL frm_resof_err: got %b want 1", err_o); else n_pass++;
    send_nib(4'h0, 1'b0);
    n_total++; if (err_o !== 1'b0) $display("FAIL frm_resof_pulse: got %b want 0", err_o); else n_pass++;
    send_nib(4'h0, 1'b0);
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL frm_not_done: got %b want 0", word_vld_o); else n_pass++;
    send_nib(4'h0, 1'b0);
    repeat (EXTRA) step();
    n_total++; if (word_vld_o !== 1'b1) $display("FAIL frm_vld: got %b want 1", word_vld_o); else n_pass++;
    n_total++; if (word_o !== 16'h0000) $display("FAIL frm_word: got %h want 0000", word_o); else n_pass++;
    step();
    n_total++; if (frame_cnt_o !== 8'd3) $display("FAIL frm_cnt: got %0d want 3", frame_cnt_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    word_rdy_i = 1'b1;
    send_nib(4'h1, 1'b1);
    send_nib(4'h2, 1'b0);
    rst = 1'b1;
    step();
    n_total++; if (nib_rdy_o !== 1'b0) $display("FAIL rmid_rdy: got %b want 0", nib_rdy_o); else n_pass++;
    n_total++; if (frame_cnt_o !== 8'd0) $display("FAIL rmid_cnt: got %0d want 0", frame_cnt_o); else n_pass++;
    rst = 1'b0;
    word_rdy_i = 1'b0;
    send_frame(4'hF, 4'hF, 4'hF, 4'hF);
    n_total++; if (word_vld_o !== 1'b1) $display("FAIL rhold_vld: got %b want 1", word_vld_o); else n_pass++;
    rst = 1'b1;
    step();
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL rhold_drop: got %b want 0", word_vld_o); else n_pass++;
    rst = 1'b0;
    word_rdy_i = 1'b1;
    send_frame(4'hF, 4'hF, 4'hF, 4'hF);
    n_total++; if (word_o !== 16'hFFFF) $display("FAIL rmid_word: got %h want ffff", word_o); else n_pass++;
    n_total++; if (l_word_o !== 16'hFFFF) $display("FAIL rmid_word_lsb: got %h want ffff", l_word_o); else n_pass++;
    step();
    n_total++; if (frame_cnt_o !== 8'd1) $display("FAIL rmid_cnt_after: got %0d want 1", frame_cnt_o); else n_pass++;
  endtask

  task automatic test_wrap();
    word_rdy_i = 1'b1;
    for (int w = 0; w < 254; w++) begin
      send_frame(4'h0, 4'h0, 4'h0, 4'h0);
      step();
    end
    n_total++; if (frame_cnt_o !== 8'd255) $display("FAIL wrap_255: got %0d want 255", frame_cnt_o); else n_pass++;
    send_frame(4'h0, 4'h0, 4'h0, 4'h0);
    step();
    n_total++; if (frame_cnt_o !== 8'd0) $display("FAIL wrap_0: got %0d want 0", frame_cnt_o); else n_pass++;
  endtask

`ifdef ADR_RX_PARITY_EN
  task automatic test_parity();
    word_rdy_i = 1'b1;
    par_i = 1'b0;
    send_nib(4'h1, 1'b1);
    send_nib(4'h2, 1'b0);
    send_nib(4'h3, 1'b0);
    send_nib(4'h4, 1'b0);
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL par_bad_check_vld: got %b want 0", word_vld_o); else n_pass++;
    step();
    n_total++; if (err_o !== 1'b1) $display("FAIL par_bad_err: got %b want 1", err_o); else n_pass++;
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL par_bad_vld: got %b want 0", word_vld_o); else n_pass++;
    step();
    n_total++; if (frame_cnt_o !== 8'd0) $display("FAIL par_bad_cnt: got %0d want 0", frame_cnt_o); else n_pass++;
    par_i = 1'b1;
    send_nib(4'h1, 1'b1);
    send_nib(4'h2, 1'b0);
    send_nib(4'h3, 1'b0);
    send_nib(4'h4, 1'b0);
    n_total++; if (word_vld_o !== 1'b0) $display("FAIL par_ok_check_vld: got %b want 0", word_vld_o); else n_pass++;
    step();
    n_total++; if (word_vld_o !== 1'b1 || word_o !== 16'h82A4) $display("FAIL par_ok_word: got vld %b word %h want 1 82a4", word_vld_o, word_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL par_ok_err: got %b want 0", err_o); else n_pass++;
    step();
    n_total++; if (frame_cnt_o !== 8'd1) $display("FAIL par_ok_cnt: got %0d want 1", frame_cnt_o); else n_pass++;
    par_i = 1'b0;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    nib_i      = 4'h0;
    nib_vld_i  = 1'b0;
    nib_sof_i  = 1'b0;
    word_rdy_i = 1'b0;
`ifdef ADR_RX_PARITY_EN
    par_i      = 1'b0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_framing();
    test_reset_mid();
    test_wrap();
`ifdef ADR_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adr_nibble_rx.md
Name: adr_nibble_rx

Overview:
Receiving end of the 4-bit address-lane interface. The driver side sends address words as a sequence of nibbles, with a fixed lane permutation: bus bit 3 is carried on pin 0 and bus bit 0 on pin 3. This block undoes that permutation, reassembles the nibbles into WORD_W-bit words and presents each word on a valid/ready output. It sits between the pin-level lane bundle and the address consumer.

Parameters:
WORD_W, 16, reassembled word width; must be a multiple of 4 and at least 8.
MSB_FIRST, 1, 1 = first nibble lands in the top bits; 0 = first nibble lands in bits [3:0].

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
nib_i  input  4  physical lane nibble; nib_i[k] is pin Ak.
nib_vld_i  input  1  nibble valid.
nib_sof_i  input  1  start-of-frame; qualifies the first nibble of a word.
nib_rdy_o  output  1  nibble accept; a nibble transfers when nib_vld_i && nib_rdy_o.
word_o  output  WORD_W  assembled word.
word_vld_o  output  1  word valid.
word_rdy_i  input  1  consumer ready.
err_o  output  1  one-cycle framing-error pulse.
frame_cnt_o  output  8  count of delivered words; wraps 255 -> 0.

Behaviour:
- Reset values: nib_rdy_o=0 during reset, word_o=0, word_vld_o=0, err_o=0, frame_cnt_o=0. The FSM resets to IDLE and the nibble index to 0.
- Reset mid-frame discards the partial word and drops any held word.
- Lane unswizzle, logical d from nib_i: d[3]=nib_i[0], d[2]=nib_i[2], d[1]=nib_i[1], d[0]=nib_i[3].
- NIB_CNT = WORD_W/4. The nibble index is clog2(NIB_CNT) bits wide.
- nib_rdy_o = 1 in IDLE and COLLECT, 0 in HOLD. A word therefore costs NIB_CNT+1 cycles minimum.
- IDLE, accepted nibble with sof=1: store d at position 0, index=1, go to COLLECT.
- IDLE, accepted nibble with sof=0: nibble discarded, err_o pulses next cycle, stay in IDLE.
- COLLECT, accepted nibble with sof=0: store d at the current index, index+1.
- COLLECT, accepted nibble with sof=1: err_o pulses, the partial word is discarded, and this nibble restarts the frame as position 0.
- COLLECT, accepted nibble at index NIB_CNT-1: go to HOLD. word_vld_o=1 in the next cycle, with word_o stable.
- Position p placement: MSB_FIRST=1 puts it at bits [WORD_W-1-4p -: 4]; MSB_FIRST=0 puts it at bits [4p +: 4].
- HOLD: word_o and word_vld_o stay stable until word_rdy_i=1. On handshake: word_vld_o=0 next cycle, frame_cnt_o+1 (wrapping), go to IDLE.
- word_vld_o never drops without a handshake, except on rst.
- nib_vld_i=0 in COLLECT: wait indefinitely; there is no timeout.
- Unaccepted input (nib_rdy_o=0) has no effect, including sof.
- err_o is registered and lasts exactly one cycle per error event.

Optional Feature:
ADR_RX_PARITY_EN.
- Defined: adds input port par_i (1 bit), sampled together with the last nibble of a frame. Expected value is even parity, i.e. ^word == par_i.
  - On mismatch: the word is dropped, err_o pulses, the FSM returns to IDLE, frame_cnt_o is unchanged and word_vld_o is never raised.
  - On match: behaviour is as above, with one extra cycle before word_vld_o to register the parity check.
- Undefined: there is no par_i port and no parity logic; latency is as specified above.

Decomposition:
- Package adr_nib_pkg holds:
  - NIB_W=4;
  - state enum {IDLE, COLLECT, HOLD}, plus CHECK when parity is enabled;
  - lane-map constant LANE_MAP = {0,2,1,3}, indexed by logical bit and giving the physical pin;
  - the unswizzle function.
- One natural sub-module is adr_nib_unswizzle: combinational, 4-in/4-out, driven by LANE_MAP. The driver-side team reuses it with the inverse map.

Test Plan:
1. WORD_W=16, MSB_FIRST=1. Send nib_i 0x1(sof), 0x2, 0x3, 0x4 back-to-back with word_rdy_i=1. Expect word_o=0x82A4, word_vld_o high one cycle after the 4th nibble, frame_cnt_o=1.
2. Same nibbles with MSB_FIRST=0. Expect word_o=0x4A28.
3. Backpressure: hold word_rdy_i=0 for 5 cycles after a word completes. Expect word_vld_o and word_o stable, nib_rdy_o=0, and a nibble offered during HOLD not consumed. Release: expect the handshake, then nib_rdy_o=1.
4. Framing: send 0x5 without sof in IDLE, expect err_o pulse and the nibble dropped. Then send 0x1(sof), 0x2, 0x0(sof), 0x0, 0x0, 0x0. Expect err_o at the 3rd nibble and word_o=0x0000.
5. Reset after 2 nibbles of a frame, then send a full frame 0xF×4 with sof. Expect word_o=0xFFFF and frame_cnt_o=1. Wrap: deliver 256 words and expect frame_cnt_o=0.
6. ADR_RX_PARITY_EN: send word 0x82A4 (odd popcount 5) with par_i=0. Expect the word dropped, err_o pulse and frame_cnt_o unchanged. Resend with par_i=1: expect delivery.
